// File: rtl/ioblock_cfg_writer_if.sv
// Host-side byte stream into the ioblock configuration writer.
// The host is the master; the writer is the slave.
interface ioblock_cfg_writer_if;
  logic [7:0] S_DATA;
  logic       S_VALID;
  logic       S_READY;

  modport master (output S_DATA, output S_VALID, input S_READY);
  modport slave  (input S_DATA, input S_VALID, output S_READY);
endinterface

// File: rtl/ioblock_cfg_writer.sv
// Configuration writer for the ioblock daisy chain. It collects a frame from the
// host byte stream, shifts it in, re-shifts it to verify, then commits it with a latch strobe.
module ioblock_cfg_writer #(
  parameter int NUM_IOB      = 8,
  parameter int BITS_PER_IOB = 3
) (
  input  logic                IOCLK,
  input  logic                RSTN,
  ioblock_cfg_writer_if.slave host,
  output logic                CFG_SDO,
  output logic                CFG_SEN,
  input  logic                CFG_SDI,
  output logic                CFG_LATCH,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);
  localparam int FRAME_BITS  = NUM_IOB * BITS_PER_IOB;
  localparam int FRAME_BYTES = (FRAME_BITS + 7) / 8;
  localparam int BIT_W       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int BYTE_W      = $clog2(FRAME_BYTES + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT1, SHIFT2, LATCH} stateT;

  stateT                 state;
  stateT                 nextState;
  logic                  armed;
  logic [BYTE_W-1:0]     byteCnt;
  logic [BYTE_W-1:0]     writeSel;
  logic [BIT_W-1:0]      bitIdx;
  logic [FRAME_BITS-1:0] frameBuf;
  logic                  errReg;
  logic                  sReady;
  logic                  accept;
  logic                  curBit;

  assign accept   = host.S_VALID & sReady;
  assign writeSel = (state == IDLE) ? '0 : byteCnt;
  assign curBit   = frameBuf[bitIdx];

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Outputs are decoded from the state. S_READY stays low until the first
  // clock after reset release, so nothing is accepted while reset is active.
  always_comb begin
    nextState = state;
    sReady    = 1'b0;
    CFG_SEN   = 1'b0;
    CFG_SDO   = 1'b0;
    CFG_LATCH = 1'b0;
    DONE      = 1'b0;
    BUSY      = 1'b1;
    case (state)
      IDLE: begin
        BUSY   = 1'b0;
        sReady = armed;
        if (accept) begin
          nextState = (FRAME_BYTES == 1) ? SHIFT1 : LOAD;
        end
      end
      LOAD: begin
        sReady = 1'b1;
        if (accept && (byteCnt == LAST_BYTE)) begin
          nextState = SHIFT1;
        end
      end
      SHIFT1: begin
        CFG_SEN = 1'b1;
        CFG_SDO = curBit;
        if (bitIdx == '0) begin
          nextState = SHIFT2;
        end
      end
      SHIFT2: begin
        CFG_SEN = 1'b1;
        CFG_SDO = curBit;
        if (bitIdx == '0) begin
          nextState = LATCH;
        end
      end
      LATCH: begin
        DONE      = 1'b1;
        CFG_LATCH = ~errReg;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign host.S_READY = sReady;
  assign ERR          = errReg;

  // Frame capture, byte counting, and readiness after reset.
  // Padding bits beyond the chain length are never stored.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      armed    <= 1'b0;
      byteCnt  <= '0;
      frameBuf <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        byteCnt <= writeSel + 1'b1;
        for (int k = 0; k < FRAME_BITS; k++) begin
          if (writeSel == BYTE_W'(k / 8)) begin
            frameBuf[k] <= host.S_DATA[k % 8];
          end
        end
      end
    end
  end

  // The bit index walks MSB to LSB in each pass and is explicitly reloaded at
  // every pass boundary, so both passes send the identical sequence.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      bitIdx <= '0;
    end else begin
      case (state)
        SHIFT1:  bitIdx <= (bitIdx == '0) ? LAST_BIT : bitIdx - 1'b1;
        SHIFT2:  bitIdx <= (bitIdx == '0) ? '0 : bitIdx - 1'b1;
        default: if (nextState == SHIFT1) bitIdx <= LAST_BIT;
      endcase
    end
  end

  // ERR is sticky from the first verify mismatch until the next frame starts.
  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      errReg <= 1'b0;
    end else if (accept && (state == IDLE)) begin
      errReg <= 1'b0;
    end else if ((state == SHIFT2) && (CFG_SDI != curBit)) begin
      errReg <= 1'b1;
    end
  end

  assert property (@(posedge IOCLK) disable iff (!RSTN)
    CFG_SEN |-> ((state == SHIFT1) || (state == SHIFT2)));
  assert property (@(posedge IOCLK) disable iff (!RSTN) !CFG_SEN |-> !CFG_SDO);
  assert property (@(posedge IOCLK) disable iff (!RSTN) CFG_LATCH |-> DONE);

endmodule

// File: tb/tb_ioblock_cfg_writer.sv
// Self-checking bench for ioblock_cfg_writer. It uses an ideal shift-chain model with an
// optional stuck-at-0 cell, and predicts outputs from the frame contents.
module tb_ioblock_cfg_writer;
  localparam int NUM_IOB      = 8;
  localparam int BITS_PER_IOB = 3;
  localparam int FRAME_BITS   = NUM_IOB * BITS_PER_IOB;
  localparam int FRAME_BYTES  = (FRAME_BITS + 7) / 8;
  localparam int DONE_LAT     = 2 * FRAME_BITS + 1;

  logic IOCLK = 1'b0;
  logic RSTN  = 1'b0;
  logic CFG_SDO, CFG_SEN, CFG_SDI, CFG_LATCH, BUSY, DONE, ERR;
  int   total = 0;
  int   bad   = 0;

  ioblock_cfg_writer_if hostBus();

  ioblock_cfg_writer #(.NUM_IOB(NUM_IOB), .BITS_PER_IOB(BITS_PER_IOB)) dut (
    .IOCLK(IOCLK), .RSTN(RSTN), .host(hostBus),
    .CFG_SDO(CFG_SDO), .CFG_SEN(CFG_SEN), .CFG_SDI(CFG_SDI),
    .CFG_LATCH(CFG_LATCH), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 IOCLK = ~IOCLK;

  // The chain model holds position k in chain[k]. The head is position 0 and the tail is the last position.
  logic [FRAME_BITS-1:0] chain  = '0;
  logic [FRAME_BITS-1:0] shadow = '0;
  int stuckBit = -1;
  assign CFG_SDI = chain[FRAME_BITS-1];

  always @(posedge IOCLK) begin : chainModel
    logic [FRAME_BITS-1:0] nxt;
    nxt = chain;
    if (CFG_SEN) nxt = {chain[FRAME_BITS-2:0], CFG_SDO};
    if (stuckBit >= 0) nxt[stuckBit] = 1'b0;
    chain <= nxt;
    if (CFG_LATCH) shadow <= chain;
  end

  // The monitor samples outputs mid-cycle.
  int cyc = 0;
  int hsCount, lastHs, senCount, senFirst, senLast, doneCount, doneCyc, latchCount, sdoLeak;
  bit doneLatch, doneErr, errInShift;
  bit sdoQ[$];

  always @(posedge IOCLK) cyc++;

  always @(negedge IOCLK) begin
    if (hostBus.S_VALID && hostBus.S_READY) begin
      hsCount++;
      lastHs = cyc;
    end
    if (CFG_SEN) begin
      if (senCount == 0) senFirst = cyc;
      senLast = cyc;
      senCount++;
      sdoQ.push_back(CFG_SDO);
      if (ERR) errInShift = 1'b1;
    end else if (CFG_SDO) begin
      sdoLeak++;
    end
    if (DONE) begin
      doneCount++;
      doneCyc   = cyc;
      doneLatch = CFG_LATCH;
      doneErr   = ERR;
    end
    if (CFG_LATCH) latchCount++;
  end

  task automatic tick();
    @(posedge IOCLK);
    #1;
  endtask

  task automatic clearMon();
    hsCount = 0; lastHs = 0; senCount = 0; senFirst = 0; senLast = 0;
    doneCount = 0; doneCyc = 0; latchCount = 0;
    doneLatch = 1'b0; doneErr = 1'b0; errInShift = 1'b0;
    sdoQ.delete();
  endtask

  // The reference model sends the frame MSB first in each pass, twice.
  function automatic int sdoErrors(input logic [FRAME_BITS-1:0] frame);
    int n = 0;
    if (sdoQ.size() != 2 * FRAME_BITS) return 2 * FRAME_BITS;
    for (int j = 0; j < 2 * FRAME_BITS; j++)
      if (sdoQ[j] !== frame[FRAME_BITS-1-(j % FRAME_BITS)]) n++;
    return n;
  endfunction

  // IOB n should commit TSMUX = frame[3n+1:3n] and DORREG = frame[3n+2].
  function automatic int shadowErrors(input logic [FRAME_BITS-1:0] frame);
    int n = 0;
    for (int i = 0; i < NUM_IOB; i++) begin
      if (shadow[3*i +: 2] !== frame[3*i +: 2]) n++;
      if (shadow[3*i+2] !== frame[3*i+2]) n++;
    end
    return n;
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input int gap, input bit hold, output bit ok);
    hostBus.S_VALID = 1'b0;
    repeat (gap) tick();
    hostBus.S_DATA  = b;
    hostBus.S_VALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (hostBus.S_READY) ok = 1'b1;
      tick();
    end
    if (hold) hostBus.S_DATA = 8'($urandom);
    else hostBus.S_VALID = 1'b0;
  endtask

  task automatic sendFrame(input logic [FRAME_BITS-1:0] frame, input int gap, input bit hold, output bit ok);
    logic [8*FRAME_BYTES-1:0] padded;
    bit okB;
    padded = '0;
    padded[FRAME_BITS-1:0] = frame;
    ok = 1'b1;
    for (int b = 0; b < FRAME_BYTES; b++) begin
      applyStimulus(padded[8*b +: 8], gap, hold && (b == FRAME_BYTES-1), okB);
      ok &= okB;
    end
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (DONE) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    hostBus.S_VALID = 1'b1;
    hostBus.S_DATA  = 8'hFF;
    RSTN = 1'b0;
    clearMon();
    repeat (3) tick();
    total++;
    if ({hostBus.S_READY, CFG_SDO, CFG_SEN, CFG_LATCH, BUSY, DONE, ERR} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000000",
               {hostBus.S_READY, CFG_SDO, CFG_SEN, CFG_LATCH, BUSY, DONE, ERR});
    end
    total++;
    if (hsCount !== 0) begin
      bad++;
      $display("[TB] FAIL reset_no_accept: got %0d handshakes expected 0", hsCount);
    end
    RSTN = 1'b1;
    hostBus.S_VALID = 1'b0;
    tick();
    total++;
    if (hostBus.S_READY !== 1'b1 || BUSY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", hostBus.S_READY, BUSY);
    end
  endtask

  task automatic test_nominal();
    logic [FRAME_BITS-1:0] frame;
    bit ok;
    frame = 24'h7E3CA5;
    stuckBit = -1;
    clearMon();
    sendFrame(frame, 0, 1'b0, ok);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL nominal_done_timeout: got no DONE expected DONE");
    end
    tick();
    total++;
    if (senCount !== 2 * FRAME_BITS || senLast - senFirst + 1 !== 2 * FRAME_BITS) begin
      bad++;
      $display("[TB] FAIL nominal_sen_run: got count=%0d span=%0d expected %0d", senCount, senLast - senFirst + 1, 2 * FRAME_BITS);
    end
    total++;
    if (sdoErrors(frame) !== 0) begin
      bad++;
      $display("[TB] FAIL nominal_sdo_seq: got %0d wrong bits expected 0", sdoErrors(frame));
    end
    total++;
    if (doneCyc - lastHs !== DONE_LAT || doneLatch !== 1'b1 || doneErr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nominal_done: got lat=%0d latch=%b err=%b expected lat=%0d latch=1 err=0",
               doneCyc - lastHs, doneLatch, doneErr, DONE_LAT);
    end
    total++;
    if (shadow[1:0] !== 2'b01 || shadow[2] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nominal_iob0: got tsmux=%b dorreg=%b expected tsmux=01 dorreg=1", shadow[1:0], shadow[2]);
    end
  endtask

  task automatic test_verify_fail();
    bit ok;
    stuckBit = 10;
    clearMon();
    sendFrame('1, 0, 1'b0, ok);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL verify_done_timeout: got no DONE expected DONE");
    end
    tick();
    total++;
    if (errInShift !== 1'b1 || doneLatch !== 1'b0 || doneCount !== 1 || latchCount !== 0) begin
      bad++;
      $display("[TB] FAIL verify_err: got errInShift=%b latch=%b done=%0d latches=%0d expected 1 0 1 0",
               errInShift, doneLatch, doneCount, latchCount);
    end
    repeat (5) tick();
    total++;
    if (ERR !== 1'b1) begin
      bad++;
      $display("[TB] FAIL verify_err_sticky: got %b expected 1", ERR);
    end
    stuckBit = -1;
  endtask

  task automatic test_gaps();
    logic [FRAME_BITS-1:0] frame;
    bit ok;
    frame = FRAME_BITS'($urandom);
    clearMon();
    sendFrame(frame, 5, 1'b1, ok);
    waitDone(ok);
    total++;
    if (!ok || hostBus.S_READY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL gaps_done: got done=%b ready=%b expected done=1 ready=0", ok, hostBus.S_READY);
    end
    hostBus.S_VALID = 1'b0;
    tick();
    total++;
    if (senFirst !== lastHs + 1 || hsCount !== FRAME_BYTES) begin
      bad++;
      $display("[TB] FAIL gaps_order: got senFirst=%0d lastHs=%0d hs=%0d expected senFirst=lastHs+1 hs=%0d",
               senFirst, lastHs, hsCount, FRAME_BYTES);
    end
    total++;
    if (sdoErrors(frame) !== 0 || shadowErrors(frame) !== 0 || doneLatch !== 1'b1) begin
      bad++;
      $display("[TB] FAIL gaps_data: got sdoErr=%0d shadowErr=%0d latch=%b expected 0 0 1",
               sdoErrors(frame), shadowErrors(frame), doneLatch);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [FRAME_BITS-1:0] frame;
    bit ok;
    clearMon();
    sendFrame(FRAME_BITS'($urandom), 0, 1'b0, ok);
    for (int i = 0; i < 200 && senCount < FRAME_BITS + 7; i++) tick();
    RSTN = 1'b0;
    #1;
    total++;
    if (CFG_SEN !== 1'b0 || CFG_SDO !== 1'b0 || BUSY !== 1'b0 || senCount !== FRAME_BITS + 7) begin
      bad++;
      $display("[TB] FAIL midreset_drop: got sen=%b sdo=%b busy=%b senCount=%0d expected 0 0 0 %0d",
               CFG_SEN, CFG_SDO, BUSY, senCount, FRAME_BITS + 7);
    end
    repeat (3) tick();
    RSTN = 1'b1;
    repeat (2) tick();
    total++;
    if (latchCount !== 0 || doneCount !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_no_latch: got latches=%0d dones=%0d expected 0 0", latchCount, doneCount);
    end
    frame = FRAME_BITS'($urandom);
    clearMon();
    sendFrame(frame, 1, 1'b0, ok);
    waitDone(ok);
    tick();
    total++;
    if (!ok || doneLatch !== 1'b1 || shadowErrors(frame) !== 0 || doneCyc - lastHs !== DONE_LAT) begin
      bad++;
      $display("[TB] FAIL midreset_next_frame: got done=%b latch=%b shadowErr=%0d lat=%0d expected 1 1 0 %0d",
               ok, doneLatch, shadowErrors(frame), doneCyc - lastHs, DONE_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [FRAME_BITS-1:0] frame2;
    bit ok;
    bit okB;
    stuckBit = 4;
    clearMon();
    sendFrame(FRAME_BITS'($urandom) | 1, 0, 1'b0, ok);
    waitDone(ok);
    stuckBit = -1;
    tick();
    frame2 = FRAME_BITS'($urandom);
    clearMon();
    hostBus.S_DATA  = frame2[7:0];
    hostBus.S_VALID = 1'b1;
    total++;
    if (!ok || ERR !== 1'b1 || hostBus.S_READY !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_before: got done=%b err=%b ready=%b expected 1 1 1", ok, ERR, hostBus.S_READY);
    end
    tick();
    hostBus.S_VALID = 1'b0;
    total++;
    if (ERR !== 1'b0 || BUSY !== 1'b1 || hsCount !== 1) begin
      bad++;
      $display("[TB] FAIL b2b_err_clear: got err=%b busy=%b hs=%0d expected 0 1 1", ERR, BUSY, hsCount);
    end
    applyStimulus(frame2[15:8], 0, 1'b0, okB);
    applyStimulus(frame2[23:16], 0, 1'b0, ok);
    ok &= okB;
    waitDone(okB);
    tick();
    total++;
    if (!ok || !okB || doneLatch !== 1'b1 || sdoErrors(frame2) !== 0 || shadowErrors(frame2) !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_frame2: got ok=%b latch=%b sdoErr=%0d shadowErr=%0d expected 1 1 0 0",
               ok && okB, doneLatch, sdoErrors(frame2), shadowErrors(frame2));
    end
  endtask

  task automatic test_random();
    logic [FRAME_BITS-1:0] frame;
    bit ok;
    bit expErr;
    for (int t = 0; t < 8; t++) begin
      frame    = FRAME_BITS'($urandom);
      if (t == 3) frame = '0;
      stuckBit = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME_BITS - 1)) : -1;
      expErr   = (stuckBit >= 0) && (frame != '0);
      clearMon();
      sendFrame(frame, int'($urandom_range(0, 3)), 1'b0, ok);
      waitDone(ok);
      tick();
      total++;
      if (!ok || doneCyc - lastHs !== DONE_LAT || sdoErrors(frame) !== 0) begin
        bad++;
        $display("[TB] FAIL random_%0d_timing: got done=%b lat=%0d sdoErr=%0d expected 1 %0d 0",
                 t, ok, doneCyc - lastHs, sdoErrors(frame), DONE_LAT);
      end
      total++;
      if (doneErr !== expErr || doneLatch !== !expErr || latchCount !== int'(!expErr)) begin
        bad++;
        $display("[TB] FAIL random_%0d_verify: got err=%b latch=%b latches=%0d expected err=%b latch=%b",
                 t, doneErr, doneLatch, latchCount, expErr, !expErr);
      end
      if (!expErr) begin
        total++;
        if (shadowErrors(frame) !== 0) begin
          bad++;
          $display("[TB] FAIL random_%0d_commit: got %0d wrong fields expected 0", t, shadowErrors(frame));
        end
      end
    end
    stuckBit = -1;
    total++;
    if (sdoLeak !== 0) begin
      bad++;
      $display("[TB] FAIL sdo_idle_low: got %0d cycles with SDO high while SEN low expected 0", sdoLeak);
    end
  endtask

  initial begin
    sdoLeak = 0;
    hostBus.S_DATA  = 8'h00;
    hostBus.S_VALID = 1'b0;
    test_reset();
    test_nominal();
    test_verify_fail();
    test_back_to_back();
    test_gaps();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ioblock_cfg_writer.md
Name: ioblock_cfg_writer

Overview:
- Configuration writer for a daisy-chained string of ioblock configuration cells.
- Each cell holds TSMUX[1:0] and DORREG. The chain is one serial shift path: data enters at CFG_SDO and leaves the last cell back into CFG_SDI.
- The block accepts a configuration frame as bytes from the config host, shifts it into the chain, verifies it on a second shift pass, then pulses a latch strobe that commits the shadow bits into every ioblock.
- It sits between the bitstream loader and the IO ring.

Parameters:
- NUM_IOB, 8, number of ioblocks on the chain.
- BITS_PER_IOB, 3, config bits per ioblock: {DORREG, TSMUX[1:0]}.
- FRAME_BITS, NUM_IOB*BITS_PER_IOB (derived, localparam), chain length in bits.
- FRAME_BYTES, ceil(FRAME_BITS/8) (derived, localparam), bytes per frame.

Ports:
- IOCLK  input  1  sole clock; all state updates on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- S_DATA  input  8  frame byte from the host.
- S_VALID  input  1  S_DATA valid.
- S_READY  output  1  block accepts a byte this cycle.
- CFG_SDO  output  1  serial data into chain head.
- CFG_SEN  output  1  chain shift enable; the chain shifts one position per IOCLK while high.
- CFG_SDI  input  1  registered serial output of the chain tail.
- CFG_LATCH  output  1  one-cycle commit strobe for all shadow bits.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse at frame completion.
- ERR  output  1  sticky verify-mismatch flag.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - state=IDLE.
  - S_READY=0, CFG_SDO=0, CFG_SEN=0, CFG_LATCH=0, BUSY=0, DONE=0, ERR=0.
  - Byte counter, bit counter and frame buffer are cleared.
  - Reset mid-frame abandons the frame; CFG_LATCH is never asserted for a partial frame.
- Frame mapping:
  - Frame bit k = byte (k/8), bit (k%8); byte 0 arrives first.
  - IOB n owns bits 3n+2..3n. TSMUX = bits 3n+1:3n; DORREG = bit 3n+2.
  - Padding bits above FRAME_BITS-1 in the last byte are ignored.
- States: IDLE, LOAD, SHIFT1, SHIFT2, LATCH.
- IDLE:
  - S_READY=1.
  - A handshake (S_VALID&S_READY) stores byte 0, clears ERR and moves to LOAD. If FRAME_BYTES==1, it goes straight to SHIFT1.
- LOAD:
  - S_READY=1 until FRAME_BYTES bytes have been accepted.
  - When the last byte is accepted, S_READY drops the next cycle and the state goes to SHIFT1.
  - Gaps in S_VALID are tolerated with no timeout.
  - S_DATA is ignored when S_READY=0.
- SHIFT1:
  - Runs for FRAME_BITS cycles with CFG_SEN=1.
  - Cycle j drives CFG_SDO = frame bit (FRAME_BITS-1-j), MSB first.
  - After the pass, bit k sits in chain position k.
- SHIFT2:
  - Runs for FRAME_BITS cycles and re-sends the identical sequence.
  - In cycle j, CFG_SDI is sampled on the same edge that shifts; it must equal the bit sent in SHIFT1 cycle j.
  - Any mismatch sets ERR. ERR holds until the next frame's first byte is accepted or until reset.
- LATCH (1 cycle):
  - CFG_SEN=0.
  - DONE=1 always.
  - CFG_LATCH=1 only if ERR=0 (including a mismatch on the final SHIFT2 bit).
  - Next state is IDLE.
- Latency: from the last byte handshake to DONE is 2*FRAME_BITS+1 cycles.
- CFG_SEN is never high outside SHIFT1/SHIFT2.
- CFG_SDO=0 whenever CFG_SEN=0.
- Bit counter wraps only by explicit reload at the state change; no modulo arithmetic leaks between passes.

Test Plan:
- Reset: hold RSTN=0 with S_VALID=1 -> all outputs 0. Release -> S_READY=1 next cycle and BUSY=0.
- Nominal frame (NUM_IOB=8):
  - Send bytes 0xA5, 0x3C, 0x7E with an ideal chain model -> CFG_SEN high for 48 consecutive cycles.
  - SDO sequence in SHIFT1 = bits 23..0 of 0x7E3CA5.
  - DONE and CFG_LATCH high together exactly 49 cycles after the 3rd handshake; ERR=0.
  - Model IOB0 commits TSMUX=2'b01, DORREG=1.
- Verify fail: model forces chain bit 10 stuck-at-0, frame 0xFFFFFF -> ERR=1 during SHIFT2; DONE=1 with CFG_LATCH=0. ERR stays 1 until the next frame's first byte is accepted.
- Backpressure/gaps:
  - Insert 5 idle cycles between bytes -> no shift starts before byte 3 is accepted.
  - S_VALID held high after byte 3 -> S_READY=0 and no extra byte is consumed until DONE.
- Reset mid-SHIFT2: assert RSTN low at SHIFT2 cycle 7 -> CFG_SEN drops immediately; CFG_LATCH is never pulsed. A following full frame completes normally.
- Back-to-back frames: present frame 2 byte 0 the cycle after DONE -> accepted in IDLE. Frame 1 ERR=1 is cleared on that handshake.
